// File: rtl/router_packet_register.sv
// Packet-framing input register for the 1-to-3 router: latches header fields, checks
// trailing XOR parity and forwards every byte through a dout register plus one-entry skid.
module router_packet_register #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_PORTS  = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  in_ready,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_BITS-1:0]  dest,
    output logic                  bad_dest,
    output logic                  parity_done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  busy
);

    localparam int LEN_W = DATA_WIDTH - ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        PARITY
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [LEN_W-1:0]      remaining;
    logic [DATA_WIDTH-1:0] parity_acc;
    logic [DATA_WIDTH-1:0] skid;
    logic                  skid_full;
    logic                  accept;
    logic                  consume;
    logic                  parity_bad;
    logic [ADDR_BITS-1:0]  hdr_dest;
    logic [LEN_W-1:0]      hdr_len;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (&value) ? value : value + CNT_WIDTH'(1);
    endfunction

    function automatic logic dest_illegal(input logic [ADDR_BITS-1:0] d);
        return int'(d) >= NUM_PORTS;
    endfunction

    assign in_ready   = !skid_full;
    assign accept     = pkt_valid && in_ready;
    assign consume    = dout_valid && !fifo_full;
    assign hdr_dest   = data_in[ADDR_BITS-1:0];
    assign hdr_len    = data_in[DATA_WIDTH-1:ADDR_BITS];
    assign parity_bad = (data_in != parity_acc);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stalls (pkt_valid low) simply hold the state; there is no timeout.
    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE:    state_next = (hdr_len != '0) ? PAYLOAD : PARITY;
                PAYLOAD: if (remaining == LEN_W'(1)) state_next = PARITY;
                PARITY:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining   <= '0;
            parity_acc  <= '0;
            dest        <= '0;
            bad_dest    <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            parity_done <= 1'b0;
        end else begin
            parity_done <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        dest       <= hdr_dest;
                        remaining  <= hdr_len;
                        parity_acc <= data_in;
                        err        <= 1'b0;
                        bad_dest   <= dest_illegal(hdr_dest);
                    end
                    PAYLOAD: begin
                        parity_acc <= parity_acc ^ data_in;
                        remaining  <= remaining - LEN_W'(1);
                    end
                    PARITY: begin
                        parity_done <= 1'b1;
                        err         <= parity_bad;
                        if (parity_bad) err_count <= sat_inc(err_count);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output stage: skid only fills when dout is occupied and not draining this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            skid       <= '0;
            skid_full  <= 1'b0;
        end else if (consume) begin
            if (skid_full) begin
                dout      <= skid;
                skid_full <= 1'b0;
            end else if (accept) begin
                dout <= data_in;
            end else begin
                dout_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!dout_valid) begin
                dout       <= data_in;
                dout_valid <= 1'b1;
            end else begin
                skid      <= data_in;
                skid_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_packet_register.sv
// Randomised and directed bench for router_packet_register against a queue-based packet model.
module tb_router_packet_register;

    localparam int DW   = 8;
    localparam int AB   = 2;
    localparam int NP   = 3;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pkt_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          fifo_full = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AB-1:0] dest;
    logic          bad_dest;
    logic          parity_done;
    logic          err;
    logic [CW-1:0] err_count;
    logic          busy;

    router_packet_register #(
        .DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_PORTS(NP), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .in_ready(in_ready), .fifo_full(fifo_full), .dout(dout), .dout_valid(dout_valid),
        .dest(dest), .bad_dest(bad_dest), .parity_done(parity_done), .err(err),
        .err_count(err_count), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: output stage is a 2-deep byte FIFO; packets are byte lists.
    byte unsigned m_q[$];
    byte unsigned m_pkt[$];
    byte unsigned got_log[$];
    int           m_len = 0;
    int           m_dest = 0;
    int           m_cnt = 0;
    bit           m_bad = 0;
    bit           m_err = 0;
    bit           m_pdone = 0;
    bit           m_cons;
    bit           m_acc;
    byte unsigned m_x;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_q.delete();
            m_pkt.delete();
            m_len = 0; m_dest = 0; m_cnt = 0;
            m_bad = 0; m_err = 0; m_pdone = 0;
        end else begin
            m_cons = (m_q.size() > 0) && !fifo_full;
            m_acc  = pkt_valid && (m_q.size() < 2);
            if (m_cons) begin
                got_log.push_back(dout);
                void'(m_q.pop_front());
            end
            m_pdone = 0;
            if (m_acc) begin
                m_q.push_back(data_in);
                if (m_pkt.size() == 0) begin
                    m_len  = int'(data_in) >> AB;
                    m_dest = int'(data_in) % (1 << AB);
                    m_bad  = (m_dest >= NP);
                    m_err  = 0;
                    m_pkt.push_back(data_in);
                end else if (m_pkt.size() == m_len + 1) begin
                    m_x = 0;
                    foreach (m_pkt[i]) m_x = m_x ^ m_pkt[i];
                    m_err = (m_x != data_in);
                    if (m_err && m_cnt < MAXC) m_cnt++;
                    m_pdone = 1;
                    m_pkt.delete();
                end else begin
                    m_pkt.push_back(data_in);
                end
            end
        end
    end

    int busy_cycles = 0;
    int pdone_count = 0;

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            chk("in_ready", in_ready, m_q.size() < 2);
            chk("dout_valid", dout_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("dout", dout, m_q[0]);
            chk("dest", dest, m_dest);
            chk("bad_dest", bad_dest, m_bad);
            chk("err", err, m_err);
            chk("err_count", err_count, m_cnt);
            chk("parity_done", parity_done, m_pdone);
            chk("busy", busy, m_pkt.size() != 0);
            busy_cycles += int'(busy);
            pdone_count += int'(parity_done);
        end
    end

    byte unsigned stim[$];
    int           valid_pct = 100;
    int           full_pct = 0;
    logic [31:0]  full_mask = '0;
    int           snap_at = -1;
    logic         snap_ready;
    logic         snap_bad;
    logic [DW-1:0] snap_dout;

    task automatic run(input int budget);
        int  c = 0;
        bit  will = 0;
        forever begin
            @(negedge clock);
            if (will) void'(stim.pop_front());
            if (c == snap_at) begin
                snap_ready = in_ready;
                snap_dout  = dout;
                snap_bad   = bad_dest;
            end
            if (stim.size() == 0 || c >= budget) break;
            pkt_valid = ($urandom_range(99) < valid_pct);
            data_in   = pkt_valid ? stim[0] : 8'($urandom);
            fifo_full = ((c < 32) ? full_mask[c] : 1'b0) || ($urandom_range(99) < full_pct);
            will      = pkt_valid && in_ready;
            c++;
        end
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        chk("run_budget_left", stim.size(), 0);
        stim.delete();
    endtask

    task automatic idle(input int n);
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic push_pkt(input int len, input int d, input bit bad_par);
        byte unsigned x;
        byte unsigned b;
        b = byte'((len << AB) | d);
        x = b;
        stim.push_back(b);
        for (int i = 0; i < len; i++) begin
            b = byte'($urandom);
            x = x ^ b;
            stim.push_back(b);
        end
        stim.push_back(bad_par ? byte'(x ^ byte'($urandom_range(255, 1))) : x);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_dest"}, dest, 0);
        chk({tag, "_bad_dest"}, bad_dest, 0);
        chk({tag, "_parity_done"}, parity_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned exp_seq[5];

        repeat (2) @(posedge clock);
        #1 chk_reset_values("por");
        @(negedge clock);
        #3 reset = 1'b0;

        // Basic packet, good parity
        exp_seq = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        got_log.delete();
        pdone_count = 0;
        stim = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        run(50);
        idle(3);
        chk("t1_dest", dest, 1);
        chk("t1_err", err, 0);
        chk("t1_pdone_pulses", pdone_count, 1);
        chk("t1_out_count", got_log.size(), 5);
        for (int i = 0; i < 5 && i < got_log.size(); i++) chk("t1_out_byte", got_log[i], exp_seq[i]);

        // Bad parity, then next header clears err
        stim = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        run(50);
        idle(2);
        chk("t2_err", err, 1);
        chk("t2_err_count", err_count, 1);
        stim = {8'h05, 8'hAA, 8'hAF};
        run(50);
        idle(2);
        chk("t2_err_cleared", err, 0);
        chk("t2_err_count_held", err_count, 1);

        // Zero-length packet
        busy_cycles = 0;
        stim = {8'h02, 8'h02};
        run(50);
        idle(2);
        chk("t3_dest", dest, 2);
        chk("t3_busy_cycles", busy_cycles, 1);
        chk("t3_err", err, 0);

        // Illegal destination still forwards and checks parity
        got_log.delete();
        snap_at = 2;
        stim = {8'h0F, 8'h01, 8'h02, 8'h03, 8'h0F};
        run(50);
        idle(3);
        chk("t4_bad_dest_midpkt", snap_bad, 1);
        chk("t4_bad_dest", bad_dest, 1);
        chk("t4_dest", dest, 3);
        chk("t4_err", err, 0);
        chk("t4_out_count", got_log.size(), 5);

        // Back-pressure for 3 cycles during payload
        got_log.delete();
        snap_at = 4;
        full_mask = 32'b11100;
        stim = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        run(50);
        full_mask = '0;
        snap_at = -1;
        idle(4);
        chk("t5_in_ready_low", snap_ready, 0);
        chk("t5_dout_held", snap_dout, 8'h11);
        chk("t5_out_count", got_log.size(), 5);
        for (int i = 0; i < 5 && i < got_log.size(); i++) chk("t5_out_byte", got_log[i], exp_seq[i]);

        // Reset after the second payload byte
        stim = {8'h0D, 8'h11, 8'h22};
        run(50);
        #2 reset = 1'b1;
        #1 chk_reset_values("midpkt");
        #4 reset = 1'b0;
        stim = {8'h05, 8'hAA, 8'hAF};
        run(50);
        idle(2);
        chk("t6_err", err, 0);
        chk("t6_err_count", err_count, 0);
        chk("t6_dest", dest, 1);

        // Randomised traffic with stalls and back-pressure
        valid_pct = 70;
        full_pct = 30;
        for (int p = 0; p < 150; p++) begin
            push_pkt($urandom_range(5), $urandom_range(3), ($urandom_range(99) < 30));
            run(300);
        end
        valid_pct = 100;
        full_pct = 0;
        idle(6);

        // Drive the error counter into saturation
        for (int p = 0; p < MAXC + 5; p++) begin
            stim = {8'h01, 8'h00};
            run(50);
        end
        idle(2);
        chk("t8_err_count_sat", err_count, MAXC);
        chk("t8_err", err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_packet_register.md
# router_packet_register

Parametrised packet-level input register for the 1-to-3 router, sitting between the router input port and the destination FIFOs. It frames each packet (header, payload, parity byte), latches the destination and length from the header, accumulates running XOR parity and checks it against the trailing parity byte. It absorbs downstream back-pressure through a one-entry skid buffer, so no byte is lost or reordered.

## Interface
- DATA_WIDTH, 8, byte width; header is {length[DATA_WIDTH-1:ADDR_BITS], dest[ADDR_BITS-1:0]}
- ADDR_BITS, 2, destination field width
- NUM_PORTS, 3, number of valid destinations; dest >= NUM_PORTS is illegal
- CNT_WIDTH, 8, width of the saturating parity-error counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pkt_valid  in  1  data_in carries a byte this cycle
- data_in  in  DATA_WIDTH  input byte
- in_ready  out  1  byte accepted at the edge when pkt_valid && in_ready
- fifo_full  in  1  downstream cannot take dout this cycle
- dout  out  DATA_WIDTH  forwarded byte (header, payload and parity, all forwarded)
- dout_valid  out  1  dout holds a byte; consumed when dout_valid && !fifo_full
- dest  out  ADDR_BITS  destination of the current/last packet
- bad_dest  out  1  latched header had dest >= NUM_PORTS
- parity_done  out  1  one-cycle pulse after the parity byte is accepted
- err  out  1  parity mismatch on the last completed packet
- err_count  out  CNT_WIDTH  saturating count of parity errors
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, PAYLOAD, PARITY.
  - IDLE: the first accepted byte is the header. Latch dest and length, set parity = header, clear err and bad_dest, set bad_dest if dest >= NUM_PORTS. Go to PAYLOAD if length != 0, else PARITY.
  - PAYLOAD: each accepted byte XORs into parity and decrements the remaining count. On the last payload byte, go to PARITY.
  - PARITY: the accepted byte is compared with the accumulated parity.
    - err <= (byte != parity); err_count increments on mismatch, saturating at all-ones.
    - parity_done <= 1 for one cycle; state returns to IDLE at the same edge.
- pkt_valid low mid-packet is a stall with no timeout; the FSM holds.
- A bad destination does not stop forwarding; the packet is still framed and parity-checked.
- Output stage: the dout register plus a one-entry skid register.
  - in_ready = !skid_full.
  - An accepted byte goes to dout if dout is empty or being consumed this cycle; otherwise it goes to skid.
  - When dout is consumed and skid is full, skid moves to dout.
  - Order is strictly preserved.
- err and bad_dest hold until the next header is accepted.
- Reset values: state IDLE; dout 0; dout_valid 0; skid empty; in_ready 1; dest 0; bad_dest 0; parity_done 0; err 0; err_count 0; busy 0.
- Reset mid-packet: the packet is abandoned, skid/dout contents are dropped, and the next accepted byte is treated as a header.

## Timing
- Latency is 1 cycle: a byte accepted at edge N drives dout/dout_valid from edge N until consumed, provided the output path is free.
- dest, bad_dest and busy update at the header acceptance edge.
- parity_done and err update at the parity acceptance edge. A new header may be accepted in the very next cycle.
- While fifo_full is high: dout and dout_valid are stable. One further byte may be accepted into skid; in_ready drops at that edge.
- in_ready rises at the edge where skid drains into dout.
- Simultaneous consume and accept with skid empty: the new byte replaces dout and dout_valid stays 1.
- err_count does not wrap.

## Test plan
- Header 0x0D (dest 1, len 3), payload 0x11 0x22 0x33, parity 0x0D, fifo_full=0 -> dout sequence 0D,11,22,33,0D each one cycle after accept; dest=1; parity_done pulses once; err=0.
- Same packet with parity byte 0x00 -> err=1, err_count=1. Next header 0x05 -> err clears at that edge.
- Zero-length: header 0x02, then parity 0x02 -> dest=2; busy high for exactly one cycle; err=0.
- Header 0x0F (dest 3) -> bad_dest=1 while the packet still forwards; parity 0x0F -> err=0.
- fifo_full high for 3 cycles during payload with pkt_valid continuous -> dout holds; in_ready falls after one extra byte; all bytes arrive in order with none lost.
- Assert reset after the second payload byte -> all outputs at reset values asynchronously. Then header 0x05, payload 0xAA, parity 0xAF -> err=0 and err_count unchanged at 0.
